// File: rtl/d_sram_like_wbuf_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// d_sram_like_wbuf_bridge_pkg : bus size codes, bus FSM states, write-entry payload
// Rev 1.0
// ---------------------------------------------------------------------------
package d_sram_like_wbuf_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4
  } bus_state_t;

  // A buffered write is {addr, wpayload_t}; the address width is a bridge parameter.
  typedef struct packed {
    logic [31:0] wdata;
    logic [1:0]  size;
  } wpayload_t;

  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_to_size = SZ_BYTE;
      4'b0011, 4'b1100:                   wen_to_size = SZ_HALF;
      default:                            wen_to_size = SZ_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_sram_like_wbuf_bridge_wbuf_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wbuf_fifo : synchronous FIFO with registered occupancy, head visible on dout
// Rev 1.0
// ---------------------------------------------------------------------------
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0]  C_FULL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == C_FULL);
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/d_sram_like_wbuf_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// d_sram_like_wbuf_bridge : CPU SRAM data port to SRAM-like master with posted writes
// Rev 1.0
// ---------------------------------------------------------------------------
module d_sram_like_wbuf_bridge
  import d_sram_like_wbuf_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              longest_stall,
  output logic              data_stall,
  output logic              wbuf_empty,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  localparam int ENTRY_W = ADDR_W + $bits(wpayload_t);

  bus_state_t                  state;
  logic                        done;
  logic                        is_store, is_load, load_pend;
  logic                        push, pop, rd_done;
  logic                        full, empty;
  logic [$clog2(WBUF_DEPTH):0] count;
  logic [ENTRY_W-1:0]          din, head;
  logic [ADDR_W-1:0]           head_addr;
  wpayload_t                   head_pl;

  assign is_store  = data_sram_en & (|data_sram_wen);
  assign is_load   = data_sram_en & ~(|data_sram_wen);
  assign load_pend = is_load & ~done;
  assign push      = is_store & ~done & ~full;
  assign data_stall = (is_store & ~done & full) | load_pend;

  assign pop     = ((state == S_WR_ADDR) & data_addr_ok & data_data_ok) |
                   ((state == S_WR_DATA) & data_data_ok);
  assign rd_done = ((state == S_RD_ADDR) & data_addr_ok & data_data_ok) |
                   ((state == S_RD_DATA) & data_data_ok);

  assign din = {data_sram_addr, data_sram_wdata, wen_to_size(data_sram_wen)};
  assign {head_addr, head_pl} = head;

  assign wbuf_empty = (count == '0) & (state == S_IDLE);

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      done            <= 1'b0;
      data_req        <= 1'b0;
      data_wr         <= 1'b0;
      data_size       <= SZ_BYTE;
      data_addr       <= '0;
      data_wdata      <= '0;
      data_sram_rdata <= '0;
    end else begin
      // done marks the held MEM instruction as serviced so it is not repeated.
      if ((push & longest_stall) | rd_done) done <= 1'b1;
      else if (!longest_stall)              done <= 1'b0;

      if (rd_done) data_sram_rdata <= data_rdata;

      case (state)
        S_IDLE: begin
          if (!empty) begin
            state      <= S_WR_ADDR;
            data_req   <= 1'b1;
            data_wr    <= 1'b1;
            data_addr  <= head_addr;
            data_wdata <= head_pl.wdata;
            data_size  <= head_pl.size;
          end else if (load_pend & ~push) begin
            state      <= S_RD_ADDR;
            data_req   <= 1'b1;
            data_wr    <= 1'b0;
            data_addr  <= data_sram_addr;
            data_wdata <= data_sram_wdata;
            data_size  <= wen_to_size(data_sram_wen);
          end
        end
        S_WR_ADDR: if (data_addr_ok) begin
          data_req <= 1'b0;
          state    <= data_data_ok ? S_IDLE : S_WR_DATA;
        end
        S_WR_DATA: if (data_data_ok) state <= S_IDLE;
        S_RD_ADDR: if (data_addr_ok) begin
          data_req <= 1'b0;
          state    <= data_data_ok ? S_IDLE : S_RD_DATA;
        end
        S_RD_DATA: if (data_data_ok) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_sram_like_wbuf_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_d_sram_like_wbuf_bridge : directed stimulus, queued expectations, bus slave + monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_d_sram_like_wbuf_bridge;
  import d_sram_like_wbuf_bridge_pkg::*;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        longest_stall = 1'b0;
  logic        data_stall, wbuf_empty;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        bus_q[$];
  logic [31:0] load_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_vec = 0, n_err = 0, cyc = 0;
  int addr_dly = 0, data_dly = 0;
  bit same = 1'b0;
  int writes_done = 0, reads_done = 0, last_rd_ok_cyc = -10;
  int req_cycles = 0, first_req_cyc = -1;

  d_sram_like_wbuf_bridge #(.WBUF_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .longest_stall(longest_stall),
    .data_stall(data_stall), .wbuf_empty(wbuf_empty),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic finish_txn(input txn_t t);
    if (t.wr) begin
      mem[t.addr] = t.wdata;
      writes_done++;
    end else begin
      data_rdata = mem.exists(t.addr) ? mem[t.addr] : 32'h0;
      reads_done++;
      last_rd_ok_cyc = cyc;
    end
  endtask

  // SRAM-like slave with programmable addr_ok / data_ok latency.
  initial begin : slave
    int   phase;
    int   cnt;
    txn_t cur;
    phase = 0; cnt = 0; cur = '0;
    forever begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (rst) begin
        phase = 0; cnt = 0;
      end else if (phase == 0) begin
        if (data_req) begin
          if (cnt >= addr_dly) begin
            data_addr_ok = 1'b1;
            cnt = 0;
            cur = '{data_wr, data_size, data_addr, data_wdata};
            if (same) begin
              data_data_ok = 1'b1;
              finish_txn(cur);
            end else phase = 1;
          end else cnt++;
        end
      end else begin
        if (cnt >= data_dly) begin
          data_data_ok = 1'b1;
          finish_txn(cur);
          phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: pops expected bus transactions on handshake and expected load data on stall release.
  initial begin : monitor
    logic prev_stall;
    txn_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (data_req) begin
          req_cycles++;
          if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (data_req && data_addr_ok) begin
          if (bus_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL bus_unexpected: got wr=%0d addr=0x%08h, expected no transaction", data_wr, data_addr);
          end else begin
            e = bus_q.pop_front();
            chk("bus_wr", {31'b0, data_wr}, {31'b0, e.wr});
            chk("bus_addr", data_addr, e.addr);
            chk("bus_size", {30'b0, data_size}, {30'b0, e.size});
            if (e.wr) chk("bus_wdata", data_wdata, e.wdata);
          end
        end
        if (data_sram_en && data_sram_wen == 4'h0 && prev_stall && !data_stall) begin
          if (load_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL load_unexpected: got rdata=0x%08h, expected no load completion", data_sram_rdata);
          end else begin
            chk("load_rdata", data_sram_rdata, load_q.pop_front());
            chk("load_latency", 32'(cyc), 32'(last_rd_ok_cyc + 1));
          end
        end
        prev_stall = data_stall;
      end
    end
  end

  task automatic wait_accept(output int n);
    n = 0; #1;
    while (data_stall && n < LIMIT) begin @(negedge clk); #1; n++; end
    if (data_stall) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: data_stall still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic release_access(input int hold);
    if (hold > 0) begin
      longest_stall = 1'b1;
      repeat (hold) begin @(negedge clk); #1; chk("hold_no_stall", {31'b0, data_stall}, 32'h0); end
      longest_stall = 1'b0;
    end
    @(negedge clk);
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen,
                       input logic [1:0] exp_size, input int hold, output int stalls, output int wd);
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    bus_q.push_back('{1'b1, exp_size, addr, wdata});
    wait_accept(stalls);
    wd = writes_done;
    release_access(hold);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp, input int hold, output int stalls);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = addr; data_sram_wdata = 32'h0;
    bus_q.push_back('{1'b0, SZ_WORD, addr, 32'h0});
    load_q.push_back(exp);
    wait_accept(stalls);
    release_access(hold);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(wbuf_empty && bus_q.size() == 0) && n < 500) begin @(negedge clk); n++; end
    if (!(wbuf_empty && bus_q.size() == 0)) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: wbuf_empty=%0d pending=%0d, expected empty", wbuf_empty, bus_q.size());
    end
    #1;
  endtask

  initial begin
    int st, wd, w0, r0, c0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'b0, data_req}, 32'h0);
    chk("rst_wr", {31'b0, data_wr}, 32'h0);
    chk("rst_size", {30'b0, data_size}, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_wbuf_empty", {31'b0, wbuf_empty}, 32'h1);
    chk("rst_stall", {31'b0, data_stall}, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fill the buffer behind a slow bus, then overflow by one.
    addr_dly = 5; data_dly = 5; same = 1'b0;
    store(32'h10, 32'h1111_1111, 4'b1111, SZ_WORD, 0, st, wd); chk("st0_stall", 32'(st), 0);
    store(32'h20, 32'h2222_2222, 4'b0011, SZ_HALF, 0, st, wd); chk("st1_stall", 32'(st), 0);
    store(32'h30, 32'h3333_3333, 4'b0100, SZ_BYTE, 0, st, wd); chk("st2_stall", 32'(st), 0);
    store(32'h40, 32'h4444_4444, 4'b1111, SZ_WORD, 0, st, wd); chk("st3_stall", 32'(st), 0);
    #1; chk("fill_not_empty", {31'b0, wbuf_empty}, 32'h0);
    store(32'h50, 32'h5555_5555, 4'b1100, SZ_HALF, 0, st, wd);
    chk("full_stalled", {31'b0, (st > 0)}, 32'h1);
    chk("full_release_after_pop", 32'(wd), 32'h1);
    wait_drain();
    chk("five_writes", 32'(writes_done), 32'h5);

    // Store then dependent load: the read must wait for the write's data_ok.
    addr_dly = 2; data_dly = 2;
    c0 = cyc; first_req_cyc = -1;
    store(32'h100, 32'hDEAD_BEEF, 4'b1111, SZ_WORD, 0, st, wd);
    load(32'h100, 32'hDEAD_BEEF, 0, st);
    chk("store_req_latency", 32'(first_req_cyc), 32'(c0 + 2));
    wait_drain();

    // addr_ok and data_ok together: one req cycle, two stall cycles.
    addr_dly = 0; same = 1'b1; req_cycles = 0;
    load(32'h100, 32'hDEAD_BEEF, 0, st);
    chk("rd_fast_stall", 32'(st), 32'h2);
    wait_drain();
    chk("rd_fast_req_cycles", 32'(req_cycles), 32'h1);

    // Held store pushes once; held load reads once.
    same = 1'b0; addr_dly = 1; data_dly = 1;
    w0 = writes_done;
    store(32'h60, 32'h6666_6666, 4'b0010, SZ_BYTE, 6, st, wd);
    wait_drain();
    chk("held_store_one_push", 32'(writes_done - w0), 32'h1);
    r0 = reads_done;
    load(32'h40, 32'h4444_4444, 3, st);
    repeat (4) @(negedge clk);
    wait_drain();
    chk("held_load_one_read", 32'(reads_done - r0), 32'h1);

    // Reset while the first of three writes sits in WR_DATA.
    addr_dly = 0; data_dly = 30;
    store(32'h70, 32'h7777_7777, 4'b1111, SZ_WORD, 0, st, wd);
    store(32'h74, 32'h7474_7474, 4'b1111, SZ_WORD, 0, st, wd);
    store(32'h78, 32'h7878_7878, 4'b1111, SZ_WORD, 0, st, wd);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_busy", {31'b0, wbuf_empty}, 32'h0);
    chk("pre_rst_wr", {31'b0, data_wr}, 32'h1);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_req", {31'b0, data_req}, 32'h0);
    chk("mid_rst_wr", {31'b0, data_wr}, 32'h0);
    chk("mid_rst_size", {30'b0, data_size}, 32'h0);
    chk("mid_rst_addr", data_addr, 32'h0);
    chk("mid_rst_wdata", data_wdata, 32'h0);
    chk("mid_rst_rdata", data_sram_rdata, 32'h0);
    chk("mid_rst_wbuf_empty", {31'b0, wbuf_empty}, 32'h1);
    bus_q.delete();
    repeat (2) @(negedge clk); rst = 1'b0;
    req_cycles = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("post_rst_no_req", 32'(req_cycles), 32'h0);
    chk("post_rst_wbuf_empty", {31'b0, wbuf_empty}, 32'h1);

    chk("load_q_drained", 32'(load_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
